// File: rtl/seq_muldiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) unit with start/busy/done handshake.
// Optional macro MULDIV_EARLY_TERM_EN: multiply finishes as soon as the remaining Booth pairs are all no-ops.
module seq_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam int AW = 2 * WIDTH + 1;
  localparam int RW = WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [AW-1:0]    acc_r;  // {upper, multiplier remainder, booth q(-1)}
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvnd_r;
  logic [RW-1:0]    rem_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dbz_r;

  logic [WIDTH:0]   upper_ext_s;
  logic [WIDTH:0]   mcand_ext_s;
  logic [WIDTH:0]   sum_s;
  logic [AW-1:0]    booth_next_s;
  logic [RW-1:0]    rem_sh_s;
  logic [RW-1:0]    dvsr_ext_s;
  logic [RW-1:0]    rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s;
  logic [WIDTH-1:0] rem_mag_s;
  logic [WIDTH-1:0] hi_div_s;
  logic [WIDTH-1:0] lo_div_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             is_mul_s;
  logic             is_div_s;
  logic             last_iter_s;

  // Decode, operand magnitudes and iteration bound
  always_comb begin
    is_mul_s    = (op_code == OP_MUL);
    is_div_s    = (op_code == OP_DIV);
    abs_a_s     = a[WIDTH-1] ? (-a) : a;
    abs_b_s     = b[WIDTH-1] ? (-b) : b;
    last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // One Booth step; the sum is kept one bit wider so a most-negative multiplicand cannot overflow
  always_comb begin
    upper_ext_s = {acc_r[AW-1], acc_r[AW-1:WIDTH+1]};
    mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
    case (acc_r[1:0])
      2'b01:   sum_s = upper_ext_s + mcand_ext_s;
      2'b10:   sum_s = upper_ext_s - mcand_ext_s;
      default: sum_s = upper_ext_s;
    endcase
    booth_next_s = {sum_s, acc_r[WIDTH:1]};
  end

  // One non-restoring division step plus the final remainder correction and sign fix
  always_comb begin
    dvsr_ext_s = {2'b00, dvsr_r};
    rem_sh_s   = {rem_r[RW-2:0], quo_r[WIDTH-1]};
    if (rem_r[RW-1]) begin
      rem_nx_s = rem_sh_s + dvsr_ext_s;
    end else begin
      rem_nx_s = rem_sh_s - dvsr_ext_s;
    end
    quo_nx_s = {quo_r[WIDTH-2:0], ~rem_nx_s[RW-1]};
    if (rem_r[RW-1]) begin
      rem_mag_s = rem_r[WIDTH-1:0] + dvsr_r;
    end else begin
      rem_mag_s = rem_r[WIDTH-1:0];
    end
    hi_div_s = r_neg_r ? (-rem_mag_s) : rem_mag_s;
    lo_div_s = q_neg_r ? (-quo_r) : quo_r;
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic [CNT_W-1:0]   rem_cnt_s;
  logic [WIDTH:0]     mask_s;
  logic               early_s;
  logic [2*WIDTH-1:0] early_prod_s;

  // Remaining pairs are no-ops when every unexamined multiplier bit equals q(-1)
  always_comb begin
    rem_cnt_s    = CNT_W'(WIDTH) - cnt_r;
    mask_s       = {(WIDTH+1){1'b1}} >> cnt_r;
    early_s      = (((acc_r[WIDTH:0] ^ {(WIDTH+1){acc_r[0]}}) & mask_s) == {(WIDTH+1){1'b0}});
    early_prod_s = $signed(acc_r[AW-1:1]) >>> rem_cnt_s;
  end
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= {AW{1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      dvsr_r      <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvnd_r      <= {WIDTH{1'b0}};
      rem_r       <= {RW{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start && (is_mul_s || is_div_s)) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            if (is_mul_s) begin
              acc_r   <= {{WIDTH{1'b0}}, b, 1'b0};
              mcand_r <= a;
              state_r <= S_MUL;
            end else begin
              dvnd_r  <= a;
              dvsr_r  <= abs_b_s;
              quo_r   <= abs_a_s;
              rem_r   <= {RW{1'b0}};
              q_neg_r <= a[WIDTH-1] ^ b[WIDTH-1];
              r_neg_r <= a[WIDTH-1];
              dbz_r   <= (b == {WIDTH{1'b0}});
              state_r <= (b == {WIDTH{1'b0}}) ? S_FIX : S_DIV;
            end
          end
        end
        S_MUL: begin
`ifdef MULDIV_EARLY_TERM_EN
          if (early_s) begin
            hi      <= early_prod_s[2*WIDTH-1:WIDTH];
            lo      <= early_prod_s[WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else
`endif
          begin
            acc_r <= booth_next_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_iter_s) begin
              hi      <= booth_next_s[AW-1:WIDTH+1];
              lo      <= booth_next_s[WIDTH:1];
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= S_DONE;
            end
          end
        end
        S_DIV: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_iter_s) begin
            state_r <= S_FIX;
          end
        end
        S_FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= S_DONE;
          if (dbz_r) begin
            hi          <= dvnd_r;
            lo          <= {WIDTH{1'b1}};
            div_by_zero <= 1'b1;
          end else begin
            hi <= hi_div_s;
            lo <= lo_div_s;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end
endmodule
